pila_retorno: RTL and testbench



---
 rtl/pila_retorno.sv | 105 ++++++++++
 tb/tb_pila_retorno.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pila_retorno.sv
`timescale 1ns/1ps
// pila_retorno: return-address stack (LIFO) for subroutine call/return.
// The control unit pushes PC+1 on a call. On a return, the top-of-stack
// output q feeds the PC-source mux, so the saved address is loaded into
// the PC on the same edge that pops it.
//
// Ports:
//   clk      system clock, rising edge active
//   reset    asynchronous, active-high reset
//   push     store d on top of stack at next rising edge
//   pop      remove top entry at next rising edge
//   clr_err  synchronous clear of ovf/unf
//   d        address to push (PC+1)
//   q        current top-of-stack, combinational (0 when empty)
//   count    number of valid entries, 0..DEPTH
//   empty    count == 0
//   full     count == DEPTH
//   ovf      sticky: push attempted while full
//   unf      sticky: pop attempted while empty
module pila_retorno #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTRW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [PTRW:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW:0]    sp;
  logic [PTRW-1:0]  top_idx;
  logic [PTRW-1:0]  waddr;

  logic do_push;   // plain push with room
  logic do_pop;    // plain pop with data
  logic do_repl;   // push+pop on non-empty: overwrite top (tail call)
  logic do_first;  // push+pop on empty: behaves as a plain push
  logic ovf_set;
  logic unf_set;
  logic we;

  assign empty   = (sp == '0);
  assign full    = (sp == (PTRW+1)'(DEPTH));
  assign count   = sp;
  assign top_idx = PTRW'(sp - 1'b1);
  assign q       = empty ? '0 : mem[top_idx];

  always_comb begin
    do_push  = push & ~pop & ~full;
    ovf_set  = push & ~pop &  full;
    do_pop   = pop  & ~push & ~empty;
    unf_set  = pop  & ~push &  empty;
    do_repl  = push &  pop  & ~empty;
    do_first = push &  pop  &  empty;
    we       = do_push | do_repl | do_first;
    // Replace writes the current top; every other write lands at sp,
    // which is below DEPTH whenever a write is permitted.
    waddr    = do_repl ? top_idx : sp[PTRW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (do_push || do_first) begin
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= sp - 1'b1;
      end

      // A newly detected error takes priority over the clear.
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end

      if (unf_set) begin
        unf <= 1'b1;
      end else if (clr_err) begin
        unf <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; only sp defines which entries are valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= d;
    end
  end

endmodule

// File: tb/tb_pila_retorno.sv
`timescale 1ns/1ps
module tb_pila_retorno;

  localparam int W = 10;
  localparam int D = 16;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic [P:0]   count;
  logic         empty;
  logic         full;
  logic         ovf;
  logic         unf;

  logic [W-1:0] pc;
  logic [W-1:0] pc_next;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] eq;
    logic [P:0]   ecnt;
    logic         eovf;
    logic         eunf;
  } exp_t;

  exp_t sb[$];

  pila_retorno #(.WIDTH(W), .DEPTH(D), .PTRW(P)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clr_err(clr_err),
    .d(d), .q(q), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [W-1:0] eq, input logic [P:0] ec,
                           input logic eo, input logic eu);
    exp_t e;
    e.tag = tag; e.eq = eq; e.ecnt = ec; e.eovf = eo; e.eunf = eu;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".q"},     16'(q),     16'(e.eq));
    cmp({e.tag, ".count"}, 16'(count), 16'(e.ecnt));
    cmp({e.tag, ".empty"}, 16'(empty), 16'(e.ecnt == 0));
    cmp({e.tag, ".full"},  16'(full),  16'(e.ecnt == D));
    cmp({e.tag, ".ovf"},   16'(ovf),   16'(e.eovf));
    cmp({e.tag, ".unf"},   16'(unf),   16'(e.eunf));
  endtask

  // Drive one operation for one edge, then compare against the queued expectation.
  task automatic op(input string tag, input logic p, input logic po, input logic c,
                    input logic [W-1:0] dd, input logic [W-1:0] eq, input logic [P:0] ec,
                    input logic eo, input logic eu);
    expect_st(tag, eq, ec, eo, eu);
    @(negedge clk);
    push = p; pop = po; clr_err = c; d = dd;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    check_out();
  endtask

  initial begin
    // Reset state
    expect_st("reset", '0, '0, 1'b0, 1'b0);
    #12;
    check_out();
    @(negedge clk);
    reset = 1'b0;

    // Basic LIFO order
    op("push005", 1, 0, 0, 10'h005, 10'h005, 1, 0, 0);
    op("push0A3", 1, 0, 0, 10'h0A3, 10'h0A3, 2, 0, 0);
    op("push3FF", 1, 0, 0, 10'h3FF, 10'h3FF, 3, 0, 0);
    op("pop1",    0, 1, 0, 10'h000, 10'h0A3, 2, 0, 0);
    op("pop2",    0, 1, 0, 10'h000, 10'h005, 1, 0, 0);
    op("pop3",    0, 1, 0, 10'h000, 10'h000, 0, 0, 0);

    // Fill, overflow, drain
    for (int i = 0; i < D; i++)
      op("fill", 1, 0, 0, W'(10'h100 + i), W'(10'h100 + i), (P+1)'(i + 1), 0, 0);
    op("push_full", 1, 0, 0, 10'h200, 10'h10F, 16, 1, 0);
    op("pop_after_ovf", 0, 1, 0, 10'h000, 10'h10E, 15, 1, 0);
    op("clr_ovf", 0, 0, 1, 10'h000, 10'h10E, 15, 0, 0);
    for (int i = 0; i < D - 1; i++) begin
      int c;
      c = D - 2 - i;
      op("drain", 0, 1, 0, 10'h000, (c == 0) ? 10'h000 : W'(10'h100 + c - 1), (P+1)'(c), 0, 0);
    end

    // Underflow and clear priority
    op("pop_empty", 0, 1, 0, 10'h000, 10'h000, 0, 0, 1);
    op("clr_unf",   0, 0, 1, 10'h000, 10'h000, 0, 0, 0);
    op("clr_and_pop_empty", 0, 1, 1, 10'h000, 10'h000, 0, 0, 1);
    op("clr_unf2",  0, 0, 1, 10'h000, 10'h000, 0, 0, 0);

    // Replace top (tail call) and push+pop on empty
    op("push011", 1, 0, 0, 10'h011, 10'h011, 1, 0, 0);
    op("push022", 1, 0, 0, 10'h022, 10'h022, 2, 0, 0);
    op("replace033", 1, 1, 0, 10'h033, 10'h033, 2, 0, 0);
    op("pop_repl", 0, 1, 0, 10'h000, 10'h011, 1, 0, 0);
    op("pop_last", 0, 1, 0, 10'h000, 10'h000, 0, 0, 0);
    op("pushpop_empty", 1, 1, 0, 10'h044, 10'h044, 1, 0, 0);
    op("pop_044", 0, 1, 0, 10'h000, 10'h000, 0, 0, 0);

    // Asynchronous reset between edges
    op("push155", 1, 0, 0, 10'h155, 10'h155, 1, 0, 0);
    op("push2AA", 1, 0, 0, 10'h2AA, 10'h2AA, 2, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    expect_st("async_reset", '0, '0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    reset = 1'b0;
    op("push001", 1, 0, 0, 10'h001, 10'h001, 1, 0, 0);
    op("pop001",  0, 1, 0, 10'h000, 10'h000, 0, 0, 0);

    // Call/return integration with a bench-side PC register
    pc = 10'h040;
    op("call", 1, 0, 0, pc + 10'h001, 10'h041, 1, 0, 0);
    pc = 10'h200;
    @(negedge clk);
    pop = 1'b1;
    #1;
    cmp("ret_q_zero_latency", 16'(q), 16'h041);
    pc_next = q;
    @(posedge clk);
    pc = pc_next;
    #1;
    pop = 1'b0;
    cmp("ret_pc", 16'(pc), 16'h041);
    cmp("ret_count", 16'(count), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
